mc_mem_arbiter: RTL and testbench
=================================

// Module: mc_mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory of the multi-cycle core between two requesters:
//  port 0 = core (fetch/lw/sw sequencing), port 1 = loader (program load / debug access).
//  Arbitrates, latches one transaction, drives the memory for MEM_LAT cycles, returns data with a one-cycle ack.
//  Sits between the core controller/datapath address mux and the memory macro.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  MEM_LAT  2   memory read latency in cycles, legal range 1..15; rdata valid in last ACCESS cycle
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  req0       in   1   core request; held high until ack0
//  we0        in   1   core write enable (1=write, 0=read)
//  addr0      in   AW  core address
//  wdata0     in   DW  core write data
//  ack0       out  1   one-cycle completion pulse to core
//  req1/we1/addr1/wdata1/ack1    same set for the loader port
//  rd_data    out  DW  read data of the last completed read; valid while its ack is high and held after
//  busy       out  1   high when state is not IDLE
//  gnt_id     out  1   port owning the current or last transaction
//  mem_en     out  1   memory access strobe
//  mem_we     out  1   memory write strobe
//  mem_addr   out  AW  latched address
//  mem_wdata  out  DW  latched write data
//  mem_rdata  in   DW  memory read data
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately): state=IDLE; every output 0; last_gnt=1; latches 0.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: if req0|req1, select a port, latch we/addr/wdata/port, set cnt=MEM_LAT-1, go to ACCESS. Otherwise stay.
//  Arbitration: a single requester wins. If both request, the port != last_gnt wins (round-robin).
//   last_gnt and gnt_id update at the grant edge.
//  ACCESS: mem_en=1 and mem_addr/mem_wdata driven for every ACCESS cycle.
//   mem_we=1 only in the first ACCESS cycle, and only for writes.
//   cnt decrements each cycle. When cnt==0: a read captures mem_rdata into rd_data at that edge; go to DONE.
//  DONE: ack of the granted port =1 for exactly this cycle, mem_en=0; next state IDLE.
//  Latency: req sampled high in cycle 0 -> ACCESS cycles 1..MEM_LAT -> ack in cycle MEM_LAT+1.
//   Minimum issue interval is MEM_LAT+2 cycles.
//  Writes leave rd_data unchanged.
//  The requester drops req in the cycle after ack. A req still high in IDLE is a new request,
//   so back-to-back transactions are legal.
//  req dropped after grant: the latched transaction still completes and ack still pulses. Input changes after
//   grant are ignored.
//  Address/data inputs of a non-granted port are never sampled.
//  Reset during ACCESS: mem_en/mem_we drop immediately and no ack is issued. A write strobed on an earlier
//   edge is not undone.
//  ack0 and ack1 are never high together. busy=0 only in IDLE.
// CONFIGURATION
//  ARB_CORE_PRIO_EN defined: fixed priority; port 0 always wins when both request.
//   last_gnt is still tracked but not used; the loader can starve.
//  ARB_CORE_PRIO_EN undefined (default): round-robin as above.
// TESTING
//  1 Assert rst mid-run -> ack0=ack1=mem_en=mem_we=busy=0 at once; rd_data=0.
//  2 MEM_LAT=2, mem[0x10]=0xDEADBEEF; req0 read 0x10 in cycle 0 -> mem_en in cycles 1-2; ack0 in cycle 3;
//    rd_data=0xDEADBEEF.
//  3 req1 write 0x20=0x12345678 -> mem_we high for 1 cycle, ack1 in cycle 3.
//    Then core read 0x20 -> 0x12345678.
//  4 req0 and req1 held high for 4 transactions -> gnt_id sequence 0,1,0,1
//    (0,0,0,0 with ARB_CORE_PRIO_EN defined).
//  5 req0 dropped in the first ACCESS cycle -> ack0 still pulses in cycle MEM_LAT+1.
//  6 rst pulsed in the second ACCESS cycle -> no ack. After release, a new read completes normally.

Source files
------------

// File: rtl/mc_mem_arbiter.sv
// Two-port arbiter in front of the unified memory: core (port 0) and loader (port 1).
// Define ARB_CORE_PRIO_EN for fixed core priority; the default build uses round-robin.
module mc_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  // core port
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  // loader port
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  // status
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          gnt_id,
  // memory macro side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // MEM_LAT is limited to 1..15, so the down-counter fits in four bits.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          first;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          last_gnt;
  logic          gnt_q;
  logic          pick;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pick = 1'b0;
`ifdef ARB_CORE_PRIO_EN
    pick = ~req0;
`else
    if (req0 && req1) pick = ~last_gnt;
    else              pick = ~req0;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values
  // and the block's result does not depend on statement order.
  // NOTE: the transaction latches and rd_data are reset because the outputs they drive must read
  // 0 in reset; the memory array itself lives outside this block and is never reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      first     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      last_gnt  <= 1'b1;
      gnt_q     <= 1'b0;
      rd_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= ACCESS;
            gnt_q     <= pick;
            last_gnt  <= pick;
            lat_we    <= pick ? we1    : we0;
            lat_addr  <= pick ? addr1  : addr0;
            lat_wdata <= pick ? wdata1 : wdata0;
            cnt       <= CNT_INIT;
            first     <= 1'b1;
          end
        end
        ACCESS: begin
          first <= 1'b0;
          if (cnt == 4'd0) begin
            if (!lat_we) rd_data <= mem_rdata;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && first && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign ack0      = (state == DONE) && !gnt_q;
  assign ack1      = (state == DONE) &&  gnt_q;
  assign busy      = (state != IDLE);
  assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_mc_mem_arbiter.sv
// Self-checking bench for mc_mem_arbiter: a latency-accurate memory model plus a
// transaction-level reference (grant rule, ack cycle, expected read data).
module tb_mc_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, busy, gnt_id, mem_en, mem_we;
  logic [31:0] rd_data, mem_addr, mem_wdata, mem_rdata;

  int n_cmp;
  int n_err;

  mc_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rd_data(rd_data), .busy(busy), .gnt_id(gnt_id),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro model: data appears only in the MEM_LAT-th consecutive enabled cycle.
  logic [31:0] mem [256];
  logic [3:0]  en_cnt;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    en_cnt <= mem_en ? en_cnt + 4'd1 : 4'd0;
  end

  assign mem_rdata = (mem_en && en_cnt == 4'(MEM_LAT - 1)) ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;

  // Reference state: memory contents, last read result, last granted port.
  logic [31:0] ref_mem [256];
  logic [31:0] ref_rd;
  bit          ref_last;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] status();
    return {busy, gnt_id, mem_en, mem_we, ack1, ack0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ref_last = 1'b1;
    ref_rd   = 32'h0;
  endtask

  // Serves one transaction from the current req/we/addr/wdata inputs, checking every cycle
  // until the arbiter is back in IDLE.
  task automatic run_one(input bit drop_early, input bit keep_req);
    int          w;
    bit          t_we;
    logic [31:0] t_addr, t_wdata, prev_rd, exp_rd;
    logic [5:0]  exp_st;
`ifdef ARB_CORE_PRIO_EN
    w = req0 ? 0 : 1;
`else
    if (req0 && req1) w = ref_last ? 0 : 1;
    else              w = req0 ? 0 : 1;
`endif
    t_we    = (w == 1) ? we1    : we0;
    t_addr  = (w == 1) ? addr1  : addr0;
    t_wdata = (w == 1) ? wdata1 : wdata0;
    prev_rd = ref_rd;
    exp_rd  = t_we ? ref_rd : ref_mem[t_addr[7:0]];
    if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
    ref_rd   = exp_rd;
    ref_last = (w == 1);

    for (int c = 1; c <= MEM_LAT + 1; c++) begin
      step();
      if (c == 1) begin
        if (w == 1) begin
          we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
          if (drop_early) req1 = 1'b0;
        end else begin
          we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
          if (drop_early) req0 = 1'b0;
        end
      end
      if (c <= MEM_LAT) begin
        exp_st = {1'b1, 1'(w), 1'b1, 1'((c == 1) && t_we), 1'b0, 1'b0};
        n_cmp++;
        if (mem_addr !== t_addr) begin
          n_err++;
          $display("FAIL mem_addr c%0d: got %h want %h", c, mem_addr, t_addr);
        end
        if (t_we) begin
          n_cmp++;
          if (mem_wdata !== t_wdata) begin
            n_err++;
            $display("FAIL mem_wdata c%0d: got %h want %h", c, mem_wdata, t_wdata);
          end
        end
        n_cmp++;
        if (rd_data !== prev_rd) begin
          n_err++;
          $display("FAIL rd_data_hold c%0d: got %h want %h", c, rd_data, prev_rd);
        end
      end else begin
        exp_st = {1'b1, 1'(w), 1'b0, 1'b0, 1'(w == 1), 1'(w == 0)};
        n_cmp++;
        if (rd_data !== exp_rd) begin
          n_err++;
          $display("FAIL rd_data_ack: got %h want %h", rd_data, exp_rd);
        end
        if (!keep_req) begin
          if (w == 1) req1 = 1'b0;
          else        req0 = 1'b0;
        end
      end
      n_cmp++;
      if (status() !== exp_st) begin
        n_err++;
        $display("FAIL status c%0d {busy,gnt,en,we,ack1,ack0}: got %b want %b", c, status(), exp_st);
      end
    end

    step();
    exp_st = {1'b0, 1'(w), 4'b0000};
    n_cmp++;
    if (status() !== exp_st || rd_data !== exp_rd) begin
      n_err++;
      $display("FAIL idle_after: got st=%b rd=%h want st=%b rd=%h", status(), rd_data, exp_st, exp_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({status(), mem_addr, mem_wdata, rd_data} !== 102'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got st=%b addr=%h wd=%h rd=%h want all 0",
               status(), mem_addr, mem_wdata, rd_data);
    end
    // Preload the memory model while the DUT is held in reset, with requests asserted.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pl_en   = 1'b1;
      pl_addr = 8'(i);
      pl_data = (i == 16) ? 32'hDEAD_BEEF : $urandom;
      ref_mem[i] = pl_data;
      step();
    end
    pl_en = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++;
    if ({status(), rd_data} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_held: got st=%b rd=%h want 0", status(), rd_data);
    end
    rst = 1'b0;
    ref_last = 1'b1;
    ref_rd   = 32'h0;
  endtask

  task automatic test_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = 32'h0;
    run_one(1'b0, 1'b0);
    n_cmp++;
    if (rd_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL read_0x10: got %h want deadbeef", rd_data);
    end
  endtask

  task automatic test_write();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
    run_one(1'b0, 1'b0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
    run_one(1'b0, 1'b0);
    n_cmp++;
    if (rd_data !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL readback_0x20: got %h want 12345678", rd_data);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq, exp_seq;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    for (int k = 0; k < 4; k++) begin
      run_one(1'b0, 1'b1);
      seq[k] = gnt_id;
    end
    req0 = 1'b0; req1 = 1'b0;
`ifdef ARB_CORE_PRIO_EN
    exp_seq = 4'b0000;
`else
    exp_seq = 4'b1010;
`endif
    n_cmp++;
    if (seq !== exp_seq) begin
      n_err++;
      $display("FAIL rr_sequence (bit k = txn k): got %b want %b", seq, exp_seq);
    end
  endtask

  task automatic test_req_drop();
    req0 = 1'b1; we0 = 1'b0; addr0 = $urandom;
    run_one(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, d;
    a = 32'h0000_0033; d = $urandom;
    req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d;
    step();
    n_cmp++;
    if (status() !== {1'b1, 1'b1, 1'b1, 1'b1, 2'b00}) begin
      n_err++;
      $display("FAIL rstmid_first: got %b want 111100", status());
    end
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({status(), rd_data} !== 38'h0) begin
      n_err++;
      $display("FAIL rstmid_immediate: got st=%b rd=%h want 0", status(), rd_data);
    end
    req1 = 1'b0;
    step();
    step();
    rst = 1'b0;
    ref_last = 1'b1;
    ref_rd   = 32'h0;
    ref_mem[a[7:0]] = d;
    for (int c = 0; c < MEM_LAT + 2; c++) begin
      step();
      n_cmp++;
      if (status() !== 6'b000000) begin
        n_err++;
        $display("FAIL rstmid_no_ack c%0d: got %b want 000000", c, status());
      end
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = a;
    run_one(1'b0, 1'b0);
    n_cmp++;
    if (rd_data !== d) begin
      n_err++;
      $display("FAIL rstmid_readback: got %h want %h", rd_data, d);
    end
  endtask

  task automatic test_random();
    logic [1:0] pat;
    for (int it = 0; it < 40; it++) begin
      pat = 2'($urandom_range(1, 3));
      req0 = pat[0]; we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
      req1 = pat[1]; we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
      for (int k = 0; k < 2; k++)
        if (req0 || req1) run_one(1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
